// File: rtl/avalon_frame_responder_if.sv
// Avalon-MM burst-read bus between the video read master and the framebuffer responder.
interface avalon_frame_responder_if #(
  parameter int BURST_W = 6
);
  logic [31:0]        address;
  logic               read;
  logic               write;
  logic [BURST_W-1:0] burstcount;
  logic [3:0]         byteenable;
  logic [31:0]        writedata;
  logic               waitrequest;
  logic [31:0]        readdata;
  logic               readdatavalid;

  modport master (
    output address, read, write, burstcount, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, burstcount, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_frame_responder.sv
// Framebuffer stand-in: answers one Avalon-MM read burst at a time with a
// pixel pattern derived from the word address, after a fixed latency and with
// optional idle gaps, and keeps sticky flags for protocol/address misuse.
module avalon_frame_responder #(
  parameter int HDISP        = 800,
  parameter int VDISP        = 480,
  parameter int READ_LATENCY = 3,
  parameter int GAP_EVERY    = 0,
  parameter int BURST_W      = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_frame_responder_if.slave  bus,
  output logic                     addr_err,
  output logic                     proto_err,
  output logic [31:0]              beats_sent
);

  localparam logic [29:0]        FRAME_WORDS = 30'(HDISP * VDISP);
  localparam logic [3:0]         LAT_LOAD    = 4'(READ_LATENCY - 1);
  localparam logic [15:0]        GAP_LAST    = 16'(GAP_EVERY - 1);
  localparam bit                 GAPS_ON     = (GAP_EVERY > 0);
  localparam bit                 LAT_ONE     = (READ_LATENCY == 1);
  localparam logic [BURST_W-1:0] ONE_BEAT    = 1;

  typedef enum logic [1:0] {IDLE, LAT, BURST, GAP} state_e;

  state_e             state_q, state_d;
  logic [29:0]        wordIdx_q, wordIdx_d;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic [3:0]         latCnt_q, latCnt_d;
  logic [15:0]        gapCnt_q, gapCnt_d;
  logic               oob_q, oob_d;
  logic               waitReq_q, waitReq_d;
  logic               rdValid_q, rdValid_d;
  logic [31:0]        rdData_q, rdData_d;
  logic               addrErr_q, addrErr_d;
  logic               protoErr_q, protoErr_d;
  logic [31:0]        beatsSent_q, beatsSent_d;

  logic               accept;
  logic               burstZero;
  logic [29:0]        wordIn;
  logic               unusedOk;

  assign accept    = (state_q == IDLE) && !waitReq_q && (bus.read || bus.write);
  assign burstZero = (bus.burstcount == '0);
  assign wordIn    = bus.address[31:2];
  assign unusedOk  = ^{bus.byteenable, bus.writedata};

  // State register plus every registered datapath value and output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wordIdx_q   <= '0;
      remain_q    <= '0;
      latCnt_q    <= '0;
      gapCnt_q    <= '0;
      oob_q       <= 1'b0;
      waitReq_q   <= 1'b1;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      addrErr_q   <= 1'b0;
      protoErr_q  <= 1'b0;
      beatsSent_q <= '0;
    end else begin
      state_q     <= state_d;
      wordIdx_q   <= wordIdx_d;
      remain_q    <= remain_d;
      latCnt_q    <= latCnt_d;
      gapCnt_q    <= gapCnt_d;
      oob_q       <= oob_d;
      waitReq_q   <= waitReq_d;
      rdValid_q   <= rdValid_d;
      rdData_q    <= rdData_d;
      addrErr_q   <= addrErr_d;
      protoErr_q  <= protoErr_d;
      beatsSent_q <= beatsSent_d;
    end
  end

  // Next state: command capture, latency countdown, beat walking and gap insertion.
  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    remain_d   = remain_q;
    latCnt_d   = latCnt_q;
    gapCnt_d   = gapCnt_q;
    oob_d      = oob_q;
    addrErr_d  = addrErr_q;
    protoErr_d = protoErr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (burstZero || bus.write) protoErr_d = 1'b1;
          if (bus.read) begin
            wordIdx_d = wordIn;
            remain_d  = burstZero ? ONE_BEAT : bus.burstcount;
            oob_d     = (wordIn >= FRAME_WORDS);
            if ((bus.address[1:0] != 2'b00) || (wordIn >= FRAME_WORDS)) addrErr_d = 1'b1;
            gapCnt_d  = '0;
            latCnt_d  = LAT_LOAD;
            state_d   = LAT_ONE ? BURST : LAT;
          end
        end
      end
      LAT: begin
        latCnt_d = latCnt_q - 4'd1;
        if (latCnt_q == 4'd1) state_d = BURST;
      end
      BURST: begin
        remain_d  = remain_q - ONE_BEAT;
        wordIdx_d = (wordIdx_q + 30'd1 == FRAME_WORDS) ? 30'd0 : wordIdx_q + 30'd1;
        gapCnt_d  = gapCnt_q + 16'd1;
        if (remain_q == ONE_BEAT) begin
          state_d = IDLE;
        end else if (GAPS_ON && (gapCnt_q == GAP_LAST)) begin
          state_d  = GAP;
          gapCnt_d = '0;
        end
      end
      GAP: begin
        state_d = BURST;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: a beat per BURST cycle, held data otherwise, busy until the cycle after the last beat.
  always_comb begin
    rdValid_d   = (state_q == BURST);
    rdData_d    = rdData_q;
    if (rdValid_d) rdData_d = oob_q ? 32'hDEAD_BEEF : {8'h00, wordIdx_q[23:0]};
    waitReq_d   = (state_d != IDLE) || rdValid_d;
    beatsSent_d = rdValid_d ? beatsSent_q + 32'd1 : beatsSent_q;
  end

  assign bus.waitrequest   = waitReq_q;
  assign bus.readdatavalid = rdValid_q;
  assign bus.readdata      = rdData_q;
  assign addr_err          = addrErr_q;
  assign proto_err         = protoErr_q;
  assign beats_sent        = beatsSent_q;

endmodule

// File: tb/tb_avalon_frame_responder.sv
// Scoreboarded bench for the framebuffer responder: two instances (latency 3 without
// gaps, latency 1 with a gap every 4 beats) driven one command at a time.
module tb_avalon_frame_responder;

  localparam int FW    = 800 * 480;
  localparam int LAT_A = 3;
  localparam int GAP_A = 0;
  localparam int LAT_B = 1;
  localparam int GAP_B = 4;

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          cyc;
    bit          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        aeA, peA, aeB, peB;
  logic [31:0] bsA, bsB;

  avalon_frame_responder_if #(.BURST_W(6)) ifA ();
  avalon_frame_responder_if #(.BURST_W(6)) ifB ();

  avalon_frame_responder #(.READ_LATENCY(LAT_A), .GAP_EVERY(GAP_A)) dutA (
    .clk(clk), .reset(reset), .bus(ifA), .addr_err(aeA), .proto_err(peA), .beats_sent(bsA)
  );

  avalon_frame_responder #(.READ_LATENCY(LAT_B), .GAP_EVERY(GAP_B)) dutB (
    .clk(clk), .reset(reset), .bus(ifB), .addr_err(aeB), .proto_err(peB), .beats_sent(bsB)
  );

  logic        rdvW[2];
  logic        wreqW[2];
  logic [31:0] dataW[2];
  logic [31:0] bsW[2];
  logic        aeW[2];
  logic        peW[2];

  assign rdvW[0]  = ifA.readdatavalid;
  assign rdvW[1]  = ifB.readdatavalid;
  assign wreqW[0] = ifA.waitrequest;
  assign wreqW[1] = ifB.waitrequest;
  assign dataW[0] = ifA.readdata;
  assign dataW[1] = ifB.readdata;
  assign bsW[0]   = bsA;
  assign bsW[1]   = bsB;
  assign aeW[0]   = aeA;
  assign aeW[1]   = aeB;
  assign peW[0]   = peA;
  assign peW[1]   = peB;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  beat_t       expQ[$];
  int unsigned modelBeats[2] = '{0, 0};
  bit          modelAddrErr[2] = '{0, 0};
  bit          modelProtoErr[2] = '{0, 0};
  bit          idleCheck[2] = '{0, 0};

  // Free-running clock and an edge counter used to time every beat.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference pixel for beat i of a burst starting at byte address addr.
  function automatic logic [31:0] expWord(input logic [31:0] addr, input int i);
    int unsigned w;
    int unsigned v;
    w = 32'(addr[31:2]);
    if (w >= FW) return 32'hDEAD_BEEF;
    v = (w + i) % FW;
    return {8'h00, v[23:0]};
  endfunction

  task automatic setBus(input int d, input logic [31:0] addr, input logic [5:0] bc,
                        input bit rd, input bit wr);
    if (d == 0) begin
      ifA.address = addr; ifA.burstcount = bc; ifA.read = rd; ifA.write = wr;
      ifA.byteenable = 4'($urandom); ifA.writedata = $urandom;
    end else begin
      ifB.address = addr; ifB.burstcount = bc; ifB.read = rd; ifB.write = wr;
      ifB.byteenable = 4'($urandom); ifB.writedata = $urandom;
    end
  endtask

  // Presents one command, waits for acceptance, and records the model's expected beats.
  task automatic applyStimulus(input int d, input logic [31:0] addr, input int n,
                               input bit rd, input bit wr, output int accCyc);
    int  nEff;
    int  lat;
    int  gap;
    bit  ok;
    accCyc = -1;
    ok = 1'b0;
    @(negedge clk);
    setBus(d, addr, 6'(n), rd, wr);
    for (int k = 0; k < 300; k++) begin
      if (wreqW[d] == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput("acceptTimeout", 32'(wreqW[d]), 32'd0);
      setBus(d, 32'd0, 6'd0, 1'b0, 1'b0);
      return;
    end
    @(posedge clk);
    #1;
    accCyc = cyc;
    setBus(d, 32'd0, 6'd0, 1'b0, 1'b0);
    lat  = (d == 0) ? LAT_A : LAT_B;
    gap  = (d == 0) ? GAP_A : GAP_B;
    nEff = (n == 0) ? 1 : n;
    if (n == 0 || wr) modelProtoErr[d] = 1'b1;
    if (rd) begin
      if (addr[1:0] != 2'b00 || 32'(addr[31:2]) >= FW) modelAddrErr[d] = 1'b1;
      for (int i = 0; i < nEff; i++) begin
        beat_t b;
        b.dut  = d;
        b.data = expWord(addr, i);
        b.cyc  = accCyc + lat + i + ((gap > 0) ? i / gap : 0);
        b.last = (i == nEff - 1);
        expQ.push_back(b);
      end
    end
    @(negedge clk);
    checkOutput("waitAfterAccept", 32'(wreqW[d]), rd ? 32'd1 : 32'd0);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 400; k++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drainRemaining", 32'(expQ.size()), 32'd0);
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic checkFlags(input int d);
    checkOutput("addrErr", 32'(aeW[d]), 32'(modelAddrErr[d]));
    checkOutput("protoErr", 32'(peW[d]), 32'(modelProtoErr[d]));
    checkOutput("beatsSent", bsW[d], modelBeats[d]);
  endtask

  task automatic checkResetState(input int d);
    checkOutput("rstValid", 32'(rdvW[d]), 32'd0);
    checkOutput("rstWait", 32'(wreqW[d]), 32'd1);
    checkOutput("rstData", dataW[d], 32'd0);
    checkOutput("rstAddrErr", 32'(aeW[d]), 32'd0);
    checkOutput("rstProtoErr", 32'(peW[d]), 32'd0);
    checkOutput("rstBeats", bsW[d], 32'd0);
  endtask

  // Monitor: every presented beat is matched in order against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (idleCheck[d]) begin
          idleCheck[d] = 1'b0;
          checkOutput("waitAfterLast", 32'(wreqW[d]), 32'd0);
        end
        if (rdvW[d] === 1'b1) begin
          if (expQ.size() == 0 || expQ[0].dut != d) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedBeat dut=%0d actual=%h required=no beat (cycle %0d)",
                     d, dataW[d], cyc);
          end else begin
            e = expQ.pop_front();
            modelBeats[d]++;
            checkOutput("beatData", dataW[d], e.data);
            checkOutput("beatCycle", 32'(cyc), 32'(e.cyc));
            checkOutput("beatCount", bsW[d], modelBeats[d]);
            if (e.last) idleCheck[d] = 1'b1;
          end
        end
      end
    end
  end

  // Directed scenarios followed by a randomized command mix on both instances.
  initial begin
    int acc;
    int relCyc;
    int d;
    int sel;
    int n;
    int kind;
    logic [31:0] addr;

    reset = 1'b1;
    setBus(0, 32'd0, 6'd0, 1'b0, 1'b0);
    setBus(1, 32'd0, 6'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState(0);
    checkResetState(1);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] 32-beat burst from word 0");
    applyStimulus(0, 32'd0, 32, 1'b1, 1'b0, acc);
    waitDrain();
    checkFlags(0);

    $display("[TB] burst wrapping the end of the frame");
    applyStimulus(0, 32'(4 * 383990), 16, 1'b1, 1'b0, acc);
    waitDrain();
    checkFlags(0);

    $display("[TB] gapped burst on the latency-1 instance");
    applyStimulus(1, 32'd0, 8, 1'b1, 1'b0, acc);
    waitDrain();
    checkFlags(1);

    $display("[TB] out-of-range then misaligned reads");
    applyStimulus(0, 32'(4 * FW), 4, 1'b1, 1'b0, acc);
    waitDrain();
    checkFlags(0);
    applyStimulus(0, 32'd2, 3, 1'b1, 1'b0, acc);
    waitDrain();
    checkFlags(0);

    $display("[TB] protocol misuse: zero burst, read+write, write alone");
    applyStimulus(0, 32'd40, 0, 1'b1, 1'b0, acc);
    waitDrain();
    applyStimulus(0, 32'd80, 3, 1'b1, 1'b1, acc);
    waitDrain();
    applyStimulus(0, 32'd120, 5, 1'b0, 1'b1, acc);
    waitDrain();
    checkFlags(0);

    $display("[TB] reset during the fifth beat");
    applyStimulus(0, 32'd0, 32, 1'b1, 1'b0, acc);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (cyc >= acc + LAT_A + 4) break;
    end
    reset = 1'b1;
    while (expQ.size() > 1) void'(expQ.pop_back());
    @(posedge clk);
    #1;
    expQ.delete();
    for (int k = 0; k < 2; k++) begin
      modelBeats[k] = 0;
      modelAddrErr[k] = 1'b0;
      modelProtoErr[k] = 1'b0;
    end
    @(negedge clk);
    checkResetState(0);
    checkResetState(1);
    @(posedge clk);
    #1 reset = 1'b0;
    relCyc = cyc;
    applyStimulus(0, 32'd8, 2, 1'b1, 1'b0, acc);
    checkOutput("acceptAfterReset", 32'(acc), 32'(relCyc + 2));
    waitDrain();
    checkFlags(0);

    $display("[TB] randomized commands");
    for (int t = 0; t < 24; t++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: addr = 32'(4 * $urandom_range(0, FW - 1));
        1: addr = 32'(4 * (FW - 10 + $urandom_range(0, 9)));
        2: addr = 32'(4 * $urandom_range(FW, FW + 20000));
        3: addr = 32'(4 * $urandom_range(0, FW - 1) + $urandom_range(1, 3));
        4: addr = $urandom;
        default: addr = 32'($urandom_range(0, 255));
      endcase
      n    = int'($urandom_range(0, 40));
      kind = int'($urandom_range(0, 7));
      applyStimulus(d, addr, n, kind != 0, kind <= 1, acc);
      waitDrain();
      checkFlags(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
